// File: rtl/aes_v1_round_seq.sv
// aes_v1_round_seq: drives one 32-bit aes_v1 SubBytes/MixColumn unit through a full AES round; define AES_RSEQ_PERF_CNT_EN to add the perf_fu_stall counter
module aes_v1_round_seq #(
  parameter int unsigned WATCHDOG = 64
) (
  input  logic         g_clk,
  input  logic         g_resetn,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_dec,
  input  logic         req_last,
  input  logic [127:0] req_state,
  input  logic [127:0] req_key,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_state,
  output logic         rsp_err,
  output logic         fu_valid,
  output logic         fu_dec,
  output logic         fu_mix,
  output logic [31:0]  fu_rs1,
  input  logic         fu_ready,
  input  logic [31:0]  fu_rd
`ifdef AES_RSEQ_PERF_CNT_EN
  ,
  output logic [31:0]  perf_fu_stall
`endif
);
  typedef enum logic [1:0] {IDLE, SUB, MIX, DONE} fsm_t;
  fsm_t fsm;
  logic dec, last, hs, stall, abort;
  logic [1:0] idx;
  logic [31:0] wd;
  logic [127:0] key, st, ld, res, sub_nxt, mix_nxt;

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[32*c+8*r +: 8] = s[32*((inv ? c + 4 - r : c + r) % 4)+8*r +: 8];
    return o;
  endfunction

  // Merge the FU result into the current word and form each phase's exit state
  always_comb begin
    hs = fu_valid && fu_ready;
    stall = fu_valid && !fu_ready;
    abort = WATCHDOG != 0 && stall && wd == WATCHDOG - 1;
    ld = req_dec ? shift_rows(req_state, 1'b1) : req_state;
    res = st;
    res[{idx, 5'd0} +: 32] = fu_rd;
    sub_nxt = dec ? res ^ key : shift_rows(res, 1'b0) ^ (last ? key : '0);
    mix_nxt = dec ? res : res ^ key;
  end

  // Round sequencer: accept, four SubBytes ops, optional four MixColumn ops, respond
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      fsm <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_state <= '0;
      fu_valid <= 1'b0;
      fu_dec <= 1'b0;
      fu_mix <= 1'b0;
      fu_rs1 <= '0;
      idx <= '0;
      wd <= '0;
      dec <= 1'b0;
      last <= 1'b0;
      key <= '0;
      st <= '0;
    end else begin
      wd <= hs || abort ? '0 : stall ? wd + 32'd1 : wd;
      case (fsm)
        IDLE:
          if (req_valid && req_ready) begin
            dec <= req_dec;
            last <= req_last;
            key <= req_key;
            st <= ld;
            idx <= '0;
            req_ready <= 1'b0;
            fu_valid <= 1'b1;
            fu_mix <= 1'b0;
            fu_dec <= req_dec;
            fu_rs1 <= ld[31:0];
            fsm <= SUB;
          end else begin
            req_ready <= 1'b1;
          end
        SUB, MIX:
          if (abort) begin
            fu_valid <= 1'b0;
            st <= '0;
            rsp_err <= 1'b1;
            idx <= '0;
            fsm <= DONE;
          end else if (hs) begin
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              st <= fsm == SUB ? sub_nxt : mix_nxt;
              if (fsm == SUB && !last) begin
                fu_mix <= 1'b1;
                fu_rs1 <= sub_nxt[31:0];
                fsm <= MIX;
              end else begin
                fu_valid <= 1'b0;
                fsm <= DONE;
              end
            end else begin
              st <= res;
              fu_rs1 <= res[{idx + 2'd1, 5'd0} +: 32];
            end
          end
        DONE:
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
            rsp_state <= st;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err <= 1'b0;
            req_ready <= 1'b1;
            fsm <= IDLE;
          end
      endcase
    end
  end

`ifdef AES_RSEQ_PERF_CNT_EN
  // Saturating count of cycles an issued FU op waits for fu_ready
  always_ff @(posedge g_clk)
    perf_fu_stall <= !g_resetn ? '0 : stall && perf_fu_stall != '1 ? perf_fu_stall + 32'd1 : perf_fu_stall;
`endif
endmodule

// File: tb/tb_aes_v1_round_seq.sv
// tb_aes_v1_round_seq: self-checking bench with an aes_v1 FU emulator and a byte-matrix AES round model
module tb_aes_v1_round_seq;
  logic g_clk, g_resetn, req_valid, req_ready, req_dec, req_last;
  logic [127:0] req_state, req_key, rsp_state;
  logic rsp_valid, rsp_ready, rsp_err, fu_valid, fu_dec, fu_mix, fu_ready;
  logic [31:0] fu_rs1, fu_rd;
`ifdef AES_RSEQ_PERF_CNT_EN
  logic [31:0] perf_fu_stall;
`endif
  int checks = 0, failures = 0, stalls = 0, stab_err = 0, mode = 0;
  logic [7:0] sbox [256];
  logic [7:0] isbox [256];

  typedef struct {
    logic dec;
    logic last;
    logic [127:0] st;
    logic [127:0] key;
    logic [127:0] exp;
  } vec_t;
  vec_t vt [12];

  aes_v1_round_seq #(.WATCHDOG(64)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_dec(req_dec), .req_last(req_last),
    .req_state(req_state), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_state(rsp_state), .rsp_err(rsp_err),
    .fu_valid(fu_valid), .fu_dec(fu_dec), .fu_mix(fu_mix), .fu_rs1(fu_rs1),
    .fu_ready(fu_ready), .fu_rd(fu_rd)
`ifdef AES_RSEQ_PERF_CNT_EN
    , .perf_fu_stall(perf_fu_stall)
`endif
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] mixw(input logic [31:0] w, input logic inv);
    logic [7:0] a [4];
    logic [31:0] o;
    for (int r = 0; r < 4; r++) a[r] = w[8*r +: 8];
    for (int r = 0; r < 4; r++)
      o[8*r +: 8] = inv ? gm(a[r], 8'd14) ^ gm(a[(r+1)%4], 8'd11) ^ gm(a[(r+2)%4], 8'd13) ^ gm(a[(r+3)%4], 8'd9)
                        : gm(a[r], 8'd2) ^ gm(a[(r+1)%4], 8'd3) ^ a[(r+2)%4] ^ a[(r+3)%4];
    return o;
  endfunction

  function automatic logic [31:0] fu_op(input logic [31:0] w, input logic d, input logic m);
    logic [31:0] o;
    if (m) return mixw(w, d);
    for (int i = 0; i < 4; i++) o[8*i +: 8] = d ? isbox[w[8*i +: 8]] : sbox[w[8*i +: 8]];
    return o;
  endfunction

  function automatic logic [127:0] ref_round(input logic [127:0] s, input logic [127:0] k, input logic d, input logic l);
    logic [7:0] m [4][4];
    logic [7:0] t [4][4];
    logic [31:0] col;
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) m[r][c] = s[32*c+8*r +: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r][c] = d ? isbox[m[r][(c+4-r)%4]] : sbox[m[r][(c+r)%4]];
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) col[8*r +: 8] = t[r][c];
      if (d) col ^= k[32*c +: 32];
      if (!l) col = mixw(col, d);
      if (!d) col ^= k[32*c +: 32];
      o[32*c +: 32] = col;
    end
    return o;
  endfunction

  function automatic logic [127:0] bsw(input logic [127:0] x);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = x[8*(15-i) +: 8];
    return o;
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // aes_v1 emulator: answers each op after a chosen number of stall cycles and watches operand stability
  initial begin
    int left;
    logic busy;
    logic [33:0] op;
    busy = 1'b0;
    left = 0;
    op = '0;
    fu_ready = 1'b0;
    fu_rd = '0;
    forever begin
      @(negedge g_clk);
      if (fu_ready) busy = 1'b0;
      if (!fu_valid) begin
        fu_ready = 1'b0;
        busy = 1'b0;
      end else begin
        if (!busy) begin
          busy = 1'b1;
          op = {fu_dec, fu_mix, fu_rs1};
          left = mode == 0 ? 0 : mode == 1 ? int'($urandom_range(0, 5)) : 1000000;
        end else if ({fu_dec, fu_mix, fu_rs1} != op) stab_err++;
        fu_rd = fu_op(fu_rs1, fu_dec, fu_mix);
        fu_ready = left == 0;
        if (left != 0) begin
          left--;
          stalls++;
        end
      end
    end
  end

  task automatic do_round(input logic d, input logic l, input logic [127:0] s, input logic [127:0] k, input int hold,
                          output logic [127:0] res, output logic err, output int lat);
    int n;
    res = '0;
    err = 1'b0;
    lat = 0;
    req_valid = 1'b1;
    req_dec = d;
    req_last = l;
    req_state = s;
    req_key = k;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge g_clk); #1;
      n++;
    end
    if (!req_ready) begin
      check("req_ready timeout", req_ready, 1);
      req_valid = 1'b0;
      return;
    end
    @(posedge g_clk); #1;
    req_valid = 1'b0;
    req_state = '0;
    req_key = '0;
    while (!rsp_valid && lat < 300) begin
      @(posedge g_clk); #1;
      lat++;
    end
    if (!rsp_valid) begin
      check("rsp timeout", rsp_valid, 1);
      return;
    end
    res = rsp_state;
    err = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge g_clk); #1;
      check("hold rsp_valid", rsp_valid, 1);
      check("hold rsp_state", rsp_state, res);
      check("hold req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge g_clk); #1;
    rsp_ready = 1'b0;
    check("post-rsp rsp_valid", rsp_valid, 0);
    check("post-rsp req_ready", req_ready, 1);
  endtask

  initial begin
    logic [127:0] fips_s, fips_k, fips_e, pt, r1, r2;
    logic e;
    int lat, s0, n;
`ifdef AES_RSEQ_PERF_CNT_EN
    logic [31:0] p0;
`endif
    g_resetn = 1'b0;
    req_valid = 1'b0;
    req_dec = 1'b0;
    req_last = 1'b0;
    req_state = '0;
    req_key = '0;
    rsp_ready = 1'b0;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, b;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x] = b;
      isbox[b] = 8'(x);
    end
    fips_s = bsw(128'h193de3bea0f4e22b9ac68d2ae9f84808);
    fips_k = bsw(128'ha0fafe1788542cb123a339392a6c7605);
    fips_e = bsw(128'ha49c7ff2689f352b6b5bea43026a5049);
    pt = bsw(128'h00112233445566778899aabbccddeeff);
    vt[0] = '{1'b0, 1'b0, fips_s, fips_k, fips_e};
    vt[1] = '{1'b0, 1'b1, pt, 128'h0, ref_round(pt, 128'h0, 1'b0, 1'b1)};
    for (int i = 2; i < 12; i++) begin
      vt[i].dec = 1'($urandom_range(0, 1));
      vt[i].last = 1'($urandom_range(0, 1));
      vt[i].st = {$urandom, $urandom, $urandom, $urandom};
      vt[i].key = {$urandom, $urandom, $urandom, $urandom};
      vt[i].exp = ref_round(vt[i].st, vt[i].key, vt[i].dec, vt[i].last);
    end

    repeat (3) @(posedge g_clk);
    #1;
    check("reset req_ready", req_ready, 0);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset fu_valid", fu_valid, 0);
    check("reset rsp_err", rsp_err, 0);
    check("reset rsp_state", rsp_state, 0);
    g_resetn = 1'b1;
    @(posedge g_clk); #1;
    check("idle req_ready", req_ready, 1);

    for (int i = 0; i < 12; i++) begin
      do_round(vt[i].dec, vt[i].last, vt[i].st, vt[i].key, 0, r1, e, lat);
      check($sformatf("vec%0d state", i), r1, vt[i].exp);
      check($sformatf("vec%0d err", i), e, 0);
      check($sformatf("vec%0d latency", i), 128'(lat), vt[i].last ? 128'd5 : 128'd9);
    end

    do_round(1'b0, 1'b1, pt, '0, 0, r1, e, lat);
    check("trip enc latency", 128'(lat), 5);
    do_round(1'b1, 1'b1, r1, '0, 0, r2, e, lat);
    check("trip dec state", r2, pt);
    check("trip dec latency", 128'(lat), 5);

    mode = 1;
    s0 = stalls;
`ifdef AES_RSEQ_PERF_CNT_EN
    p0 = perf_fu_stall;
`endif
    for (int j = 0; j < 3; j++) begin
      do_round(1'b0, 1'b0, fips_s, fips_k, 0, r1, e, lat);
      check("stall state", r1, fips_e);
      check("stall err", e, 0);
    end
    check("stall operand stability", 128'(stab_err), 0);
`ifdef AES_RSEQ_PERF_CNT_EN
    check("perf_fu_stall", 128'(perf_fu_stall - p0), 128'(stalls - s0));
`endif

    mode = 2;
    s0 = stalls;
    do_round(1'b0, 1'b0, fips_s, fips_k, 0, r1, e, lat);
    check("watchdog err", e, 1);
    check("watchdog state", r1, 0);
    check("watchdog stall cycles", 128'(stalls - s0), 64);
    mode = 0;
    do_round(1'b0, 1'b0, fips_s, fips_k, 0, r1, e, lat);
    check("after watchdog state", r1, fips_e);
    check("after watchdog err", e, 0);

    req_valid = 1'b1;
    req_dec = 1'b0;
    req_last = 1'b0;
    req_state = fips_s;
    req_key = fips_k;
    @(posedge g_clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!fu_mix && n < 20) begin
      @(posedge g_clk); #1;
      n++;
    end
    check("mix phase reached", fu_mix, 1);
    repeat (2) @(posedge g_clk);
    #1;
    g_resetn = 1'b0;
    @(posedge g_clk); #1;
    check("midreset fu_valid", fu_valid, 0);
    check("midreset rsp_valid", rsp_valid, 0);
    check("midreset req_ready", req_ready, 0);
    g_resetn = 1'b1;
    @(posedge g_clk); #1;
    check("post-reset req_ready", req_ready, 1);
    do_round(1'b0, 1'b0, fips_s, fips_k, 0, r1, e, lat);
    check("post-reset state", r1, fips_e);

    do_round(1'b0, 1'b0, fips_s, fips_k, 10, r1, e, lat);
    check("backpressure state", r1, fips_e);
    check("final operand stability", 128'(stab_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
